// File: rtl/arbitro_pkg.sv
// Shared types and constants for the two-source round-robin arbiter.
// Imported by the arbiter and by any parent that decodes its grant or select.
package arbitro_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_t;

    localparam logic       SEL_SRC0   = 1'b0;
    localparam logic       SEL_SRC1   = 1'b1;
    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_SRC0 = 2'b01;
    localparam logic [1:0] GRANT_SRC1 = 2'b10;

endpackage

// File: rtl/arbitro_rr2.sv
// Two-requester round-robin arbiter with a bounded hold counter; drives the
// one-hot grants and the registered select for the downstream 2:1 mux.
module arbitro_rr2
    import arbitro_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 4,
    parameter int unsigned CNT_W    = $clog2(MAX_HOLD + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] grant,
    output logic       sel,
    output logic       valid,
    output logic       switch_pulse
);

    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD - 1);

    state_t           state;
    state_t           nxt_state;
    logic [CNT_W-1:0] hold_cnt;
    logic             last;      // 1 when source 1 was the most recent owner
    logic             hold_done;
    logic             entering;
    logic             direct_sw;

    // A count above the limit can only come from solo ownership; treat it as
    // exhausted so a newly arriving competitor is served on the next edge.
    assign hold_done = (hold_cnt >= HOLD_LIM);

    // NOTE: every output of this always_comb gets a default first, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        nxt_state = state;
        unique case (state)
            IDLE: begin
                unique case (req)
                    2'b01:   nxt_state = G0;
                    2'b10:   nxt_state = G1;
                    2'b11:   nxt_state = last ? G0 : G1;
                    default: nxt_state = IDLE;
                endcase
            end
            G0: begin
                if (req[0]) begin
                    if (req[1] && hold_done) nxt_state = G1;
                end else begin
                    nxt_state = req[1] ? G1 : IDLE;
                end
            end
            G1: begin
                if (req[1]) begin
                    if (req[0] && hold_done) nxt_state = G0;
                end else begin
                    nxt_state = req[0] ? G0 : IDLE;
                end
            end
            default: nxt_state = IDLE;
        endcase
    end

    assign entering  = (nxt_state != state) && (nxt_state != IDLE);
    assign direct_sw = ((state == G0) && (nxt_state == G1)) ||
                       ((state == G1) && (nxt_state == G0));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            hold_cnt     <= '0;
            last         <= 1'b1;
            grant        <= GRANT_NONE;
            sel          <= SEL_SRC0;
            valid        <= 1'b0;
            switch_pulse <= 1'b0;
        end else if (en) begin
            state        <= nxt_state;
            switch_pulse <= direct_sw;
            valid        <= (nxt_state != IDLE);

            if (entering) begin
                hold_cnt <= '0;
                last     <= (nxt_state == G1);
            end else if ((nxt_state != IDLE) && (hold_cnt < HOLD_MAX)) begin
                hold_cnt <= hold_cnt + 1'b1;
            end

            unique case (nxt_state)
                G0: begin
                    grant <= GRANT_SRC0;
                    sel   <= SEL_SRC0;
                end
                G1: begin
                    grant <= GRANT_SRC1;
                    sel   <= SEL_SRC1;
                end
                default: grant <= GRANT_NONE;   // sel keeps the last owner
            endcase
        end
    end

endmodule

// File: tb/tb_arbitro_rr2.sv
// Directed bench for arbitro_rr2 (MAX_HOLD=4): a vector table stepped one
// clock per row, plus hand sequences for reset behaviour.
module tb_arbitro_rr2;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [1:0] req;
    logic [1:0] grant;
    logic       sel;
    logic       valid;
    logic       switch_pulse;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       en;
        logic [1:0] req;
        logic [1:0] grant;
        logic       sel;
        logic       valid;
        logic       pulse;
    } vec_t;

    vec_t vecs[$];

    arbitro_rr2 #(.MAX_HOLD(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .req          (req),
        .grant        (grant),
        .sel          (sel),
        .valid        (valid),
        .switch_pulse (switch_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [1:0] e_grant,
                         input logic e_sel, input logic e_valid, input logic e_pulse);
        total++;
        if ({grant, sel, valid, switch_pulse} !== {e_grant, e_sel, e_valid, e_pulse}) begin
            bad++;
            $display("FAIL %s: got grant=%b sel=%b valid=%b pulse=%b, want grant=%b sel=%b valid=%b pulse=%b",
                     name, grant, sel, valid, switch_pulse, e_grant, e_sel, e_valid, e_pulse);
        end
    endtask

    function automatic void add(input logic e, input logic [1:0] r, input logic [1:0] g,
                                input logic s, input logic v, input logic p);
        vec_t t;
        t.en = e; t.req = r; t.grant = g; t.sel = s; t.valid = v; t.pulse = p;
        vecs.push_back(t);
    endfunction

    initial begin
        // tie after reset, then 4/4 alternation under contention
        add(1, 2'b11, 2'b01, 0, 1, 0);
        add(1, 2'b11, 2'b01, 0, 1, 0);
        add(1, 2'b11, 2'b01, 0, 1, 0);
        add(1, 2'b11, 2'b01, 0, 1, 0);
        add(1, 2'b11, 2'b10, 1, 1, 1);
        add(1, 2'b11, 2'b10, 1, 1, 0);
        add(1, 2'b11, 2'b10, 1, 1, 0);
        add(1, 2'b11, 2'b10, 1, 1, 0);
        add(1, 2'b11, 2'b01, 0, 1, 1);
        add(1, 2'b11, 2'b01, 0, 1, 0);
        // release-driven handoffs, no idle bubble
        add(1, 2'b10, 2'b10, 1, 1, 1);
        add(1, 2'b10, 2'b10, 1, 1, 0);
        add(1, 2'b01, 2'b01, 0, 1, 1);
        add(1, 2'b10, 2'b10, 1, 1, 1);
        // idle keeps sel; entry from idle gives no pulse
        add(1, 2'b00, 2'b00, 1, 0, 0);
        add(1, 2'b00, 2'b00, 1, 0, 0);
        add(1, 2'b01, 2'b01, 0, 1, 0);
        // reach hold_cnt=2 in G0, then freeze with en=0
        add(1, 2'b11, 2'b01, 0, 1, 0);
        add(1, 2'b11, 2'b01, 0, 1, 0);
        for (int i = 0; i < 5; i++) add(0, 2'b10, 2'b01, 0, 1, 0);
        add(1, 2'b10, 2'b10, 1, 1, 1);
        // counter must not advance while en=0
        add(1, 2'b11, 2'b10, 1, 1, 0);
        for (int i = 0; i < 3; i++) add(0, 2'b11, 2'b10, 1, 1, 0);
        add(1, 2'b11, 2'b10, 1, 1, 0);
        add(1, 2'b11, 2'b10, 1, 1, 0);
        add(1, 2'b11, 2'b01, 0, 1, 1);
        // pulse itself is frozen by en=0
        add(0, 2'b00, 2'b01, 0, 1, 1);
        add(1, 2'b00, 2'b00, 0, 0, 0);
        add(1, 2'b00, 2'b00, 0, 0, 0);
        // tie from idle follows the last owner
        add(1, 2'b10, 2'b10, 1, 1, 0);
        add(1, 2'b00, 2'b00, 1, 0, 0);
        add(1, 2'b11, 2'b01, 0, 1, 0);
        add(1, 2'b00, 2'b00, 0, 0, 0);
        add(1, 2'b11, 2'b10, 1, 1, 0);

        rst_n = 1'b0;
        en    = 1'b1;
        req   = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 2'b00, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            en  = vecs[i].en;
            req = vecs[i].req;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), vecs[i].grant, vecs[i].sel,
                  vecs[i].valid, vecs[i].pulse);
        end

        // asynchronous reset between edges while grant=10
        check("pre_async_rst", 2'b10, 1, 1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_now", 2'b00, 0, 0, 0);
        req = 2'b11;
        @(posedge clk);
        #1;
        check("rst_held", 2'b00, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_tie", 2'b01, 0, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
